// File: rtl/rr_grant2.sv
// Two-requester round-robin grant. On a conflict the prio port wins and
// prio then moves to whichever port was not granted.
module rr_grant2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] gnt,
  output logic [1:0] busy
);

  logic prio_q;
  logic prio_d;

  always_comb begin
    gnt    = 2'b00;
    busy   = 2'b00;
    prio_d = prio_q;

    if (req == 2'b11) begin
      if (prio_q) begin
        gnt  = 2'b10;
        busy = 2'b01;
      end else begin
        gnt  = 2'b01;
        busy = 2'b10;
      end
    end else begin
      gnt = req;
    end

    // Hand preference to the port that did not get this grant.
    if (gnt[0]) begin
      prio_d = 1'b1;
    end else if (gnt[1]) begin
      prio_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio_q <= 1'b0;
    end else begin
      prio_q <= prio_d;
    end
  end

endmodule

// File: rtl/mem_rr_arbiter.sv
// Shares one single-port, 1-cycle-latency memory between two load/store
// requesters: grant mux, read-return routing and a saturating conflict counter.
module mem_rr_arbiter #(
  parameter int PORTW     = 32,
  parameter int ADDRWIDTH = 15,
  parameter int CNTW      = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [PORTW-1:0]     d_1,
  input  logic [PORTW-1:0]     d_2,
  input  logic [ADDRWIDTH-1:0] addr_1,
  input  logic [ADDRWIDTH-1:0] addr_2,
  input  logic                 en_1_x,
  input  logic                 en_2_x,
  input  logic                 wr_1_x,
  input  logic                 wr_2_x,
  input  logic [PORTW-1:0]     bit_wr_1_x,
  input  logic [PORTW-1:0]     bit_wr_2_x,
  output logic                 busy_1,
  output logic                 busy_2,
  output logic [PORTW-1:0]     q_1,
  output logic [PORTW-1:0]     q_2,
  output logic                 q_valid_1,
  output logic                 q_valid_2,
  output logic [PORTW-1:0]     d,
  output logic [ADDRWIDTH-1:0] addr,
  output logic                 en_x,
  output logic                 wr_x,
  output logic [PORTW-1:0]     bit_wr_x,
  input  logic [PORTW-1:0]     q,
  input  logic                 cnt_clr,
  output logic [CNTW-1:0]      conflict_cnt
);

  localparam logic PORT1 = 1'b0;
  localparam logic PORT2 = 1'b1;

  logic [1:0] req;
  logic [1:0] gnt;
  logic [1:0] busy;
  logic       sel;

  assign req = {~en_2_x, ~en_1_x};

  rr_grant2 u_grant (
    .clk  (clk),
    .rst  (rst),
    .req  (req),
    .gnt  (gnt),
    .busy (busy)
  );

  assign busy_1 = busy[0];
  assign busy_2 = busy[1];
  assign sel    = gnt[1] ? PORT2 : PORT1;

  // With no grant, port 1 drives the memory; its en_1_x is then high anyway.
  always_comb begin
    d        = d_1;
    addr     = addr_1;
    en_x     = en_1_x;
    wr_x     = wr_1_x;
    bit_wr_x = bit_wr_1_x;
    if (sel == PORT2) begin
      d        = d_2;
      addr     = addr_2;
      en_x     = en_2_x;
      wr_x     = wr_2_x;
      bit_wr_x = bit_wr_2_x;
    end
  end

  logic rd_pend_q;
  logic rd_pend_d;
  logic rd_owner_q;
  logic rd_owner_d;

  always_comb begin
    rd_pend_d  = (|gnt) & wr_x;
    rd_owner_d = sel;
  end

  assign q_1       = q;
  assign q_2       = q;
  assign q_valid_1 = rd_pend_q & (rd_owner_q == PORT1);
  assign q_valid_2 = rd_pend_q & (rd_owner_q == PORT2);

  logic [CNTW-1:0] conflict_cnt_q;
  logic [CNTW-1:0] conflict_cnt_d;

  always_comb begin
    conflict_cnt_d = conflict_cnt_q;
    if (cnt_clr) begin
      conflict_cnt_d = '0;
    end else if ((req == 2'b11) && (conflict_cnt_q != {CNTW{1'b1}})) begin
      conflict_cnt_d = conflict_cnt_q + CNTW'(1);
    end
  end

  assign conflict_cnt = conflict_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_pend_q      <= 1'b0;
      rd_owner_q     <= PORT1;
      conflict_cnt_q <= '0;
    end else begin
      rd_pend_q      <= rd_pend_d;
      rd_owner_q     <= rd_owner_d;
      conflict_cnt_q <= conflict_cnt_d;
    end
  end

endmodule
